// File: rtl/dmem_access_pkg.sv
// Shared types for the memory-stage data-bus access unit: access kinds,
// bus request/response shapes and the access-unit state encoding.
package common;

  localparam int unsigned AW_C = 32;
  localparam int unsigned DW_C = 32;
  localparam int unsigned SW_C = DW_C / 8;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LBU  = 4'd2,
    MEM_LH   = 4'd3,
    MEM_LHU  = 4'd4,
    MEM_LW   = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_t;

  typedef enum logic [2:0] {
    MSIZE_BYTE = 3'd0,
    MSIZE_HALF = 3'd1,
    MSIZE_WORD = 3'd2
  } msize_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DRAIN = 3'd4
  } dstate_t;

  typedef struct packed {
    logic            valid;
    logic [AW_C-1:0] addr;
    msize_t          size;
    logic [SW_C-1:0] strobe;
    logic [DW_C-1:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic            addr_ok;
    logic            data_ok;
    logic [DW_C-1:0] data;
  } dbus_resp_t;

  function automatic logic is_load(mem_t t);
    logic r;
    case (t)
      MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW: r = 1'b1;
      default:                                  r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_store(mem_t t);
    logic r;
    case (t)
      MEM_SB, MEM_SH, MEM_SW: r = 1'b1;
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_access_store_align.sv
// Combinational request shaping: bus size, byte strobes, lane-replicated
// store data and misalignment detection from access type and address offset.
module store_align
  import common::*;
#(
  parameter int unsigned DW = 32
) (
  input  mem_t            mem_type,
  input  logic [1:0]      off,
  input  logic [DW-1:0]   wdata,
  output logic [2:0]      size,
  output logic [DW/8-1:0] strobe,
  output logic [DW-1:0]   data,
  output logic            misalign
);

  always_comb begin
    size     = MSIZE_BYTE;
    strobe   = '0;
    data     = '0;
    misalign = 1'b0;
    case (mem_type)
      MEM_LB, MEM_LBU: begin
        size = MSIZE_BYTE;
      end
      MEM_LH, MEM_LHU: begin
        size     = MSIZE_HALF;
        misalign = off[0];
      end
      MEM_LW: begin
        size     = MSIZE_WORD;
        misalign = |off;
      end
      MEM_SB: begin
        size   = MSIZE_BYTE;
        strobe = {{(DW/8-1){1'b0}}, 1'b1} << off;
        data   = {(DW/8){wdata[7:0]}};
      end
      MEM_SH: begin
        size     = MSIZE_HALF;
        misalign = off[0];
        strobe   = off[1] ? {{(DW/16){1'b1}}, {(DW/16){1'b0}}}
                          : {{(DW/16){1'b0}}, {(DW/16){1'b1}}};
        data     = {(DW/16){wdata[15:0]}};
      end
      MEM_SW: begin
        size     = MSIZE_WORD;
        misalign = |off;
        strobe   = {(DW/8){1'b1}};
        data     = wdata;
      end
      default: begin
        size = MSIZE_BYTE;
      end
    endcase
  end

endmodule

// File: rtl/dmem_access.sv
// Memory-stage data-bus access unit: issues one bus request per load/store,
// runs the addr_ok/data_ok handshake and holds the raw result for extraction.
module dmem_access
  import common::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  mem_t            req_type,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  input  logic            mem_ready,
  input  logic            flush,
  output logic            dreq_valid,
  output logic [AW-1:0]   dreq_addr,
  output logic [2:0]      dreq_size,
  output logic [DW/8-1:0] dreq_strobe,
  output logic [DW-1:0]   dreq_data,
  input  logic            dresp_addr_ok,
  input  logic            dresp_data_ok,
  input  logic [DW-1:0]   dresp_data,
  output logic            stall,
  output logic            done,
  output logic [DW-1:0]   rdata_raw,
  output logic [1:0]      rd_offset,
  output mem_t            rd_type,
  output logic            misalign
);

  dstate_t       state_q, state_d;
  dbus_req_t     req_q, req_d;
  logic          kill_q, kill_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    off_q, off_d;
  mem_t          type_q, type_d;
  logic          kill_now;

  logic [2:0]      al_size;
  logic [DW/8-1:0] al_strobe;
  logic [DW-1:0]   al_data;
  logic            al_misalign;

  store_align #(.DW(DW)) u_store_align (
    .mem_type (req_type),
    .off      (req_addr[1:0]),
    .wdata    (req_wdata),
    .size     (al_size),
    .strobe   (al_strobe),
    .data     (al_data),
    .misalign (al_misalign)
  );

  // A flush in the current cycle counts as a kill alongside one seen earlier.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    kill_d   = kill_q;
    rdata_d  = rdata_q;
    off_d    = off_q;
    type_d   = type_q;
    stall    = 1'b0;
    misalign = 1'b0;
    kill_now = kill_q | flush;
    case (state_q)
      ST_IDLE: begin
        misalign = req_valid & al_misalign;
        if (req_valid && !flush && !al_misalign) begin
          stall   = 1'b1;
          req_d   = '{valid: 1'b1, addr: req_addr, size: msize_t'(al_size),
                      strobe: al_strobe, data: al_data};
          off_d   = req_addr[1:0];
          type_d  = req_type;
          kill_d  = 1'b0;
          state_d = ST_ADDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        stall  = req_valid;
        kill_d = kill_now;
        if (dresp_addr_ok) begin
          req_d.valid = 1'b0;
          if (dresp_data_ok) begin
            if (kill_now) begin
              state_d = ST_IDLE;
            end else begin
              rdata_d = dresp_data;
              state_d = ST_HOLD;
            end
          end else begin
            state_d = kill_now ? ST_DRAIN : ST_DATA;
          end
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_DATA: begin
        stall  = req_valid;
        kill_d = kill_now;
        if (dresp_data_ok) begin
          if (kill_now) begin
            state_d = ST_IDLE;
          end else begin
            rdata_d = dresp_data;
            state_d = ST_HOLD;
          end
        end else begin
          state_d = kill_now ? ST_DRAIN : ST_DATA;
        end
      end
      ST_HOLD: begin
        if (mem_ready || flush) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_DRAIN: begin
        stall = req_valid;
        if (dresp_data_ok) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, request and capture registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      kill_q  <= 1'b0;
      rdata_q <= '0;
      off_q   <= 2'b00;
      type_q  <= MEM_NONE;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      kill_q  <= kill_d;
      rdata_q <= rdata_d;
      off_q   <= off_d;
      type_q  <= type_d;
    end
  end

  assign dreq_valid  = req_q.valid;
  assign dreq_addr   = req_q.addr;
  assign dreq_size   = req_q.size;
  assign dreq_strobe = req_q.strobe;
  assign dreq_data   = req_q.data;
  assign done        = (state_q == ST_HOLD);
  assign rdata_raw   = rdata_q;
  assign rd_offset   = off_q;
  assign rd_type     = type_q;

endmodule

// File: tb/tb_dmem_access.sv
// Self-checking bench for dmem_access: directed scenarios plus randomized
// transactions checked against a cycle-timeline reference model.
module tb_dmem_access;
  import common::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  mem_t        req_type;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_ready;
  logic        flush;
  logic        dreq_valid;
  logic [31:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [31:0] dresp_data;
  logic        stall;
  logic        done;
  logic [31:0] rdata_raw;
  logic [1:0]  rd_offset;
  mem_t        rd_type;
  logic        misalign;

  int checks = 0;
  int failures = 0;
  logic [31:0] last_rdata = 32'h0;

  always #5 clk = ~clk;

  dmem_access #(.AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_type(req_type),
    .req_addr(req_addr), .req_wdata(req_wdata), .mem_ready(mem_ready), .flush(flush),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data), .dresp_addr_ok(dresp_addr_ok),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data), .stall(stall), .done(done),
    .rdata_raw(rdata_raw), .rd_offset(rd_offset), .rd_type(rd_type), .misalign(misalign)
  );

  // One transaction against a timeline model: accept at k=0, address phase
  // for 1+a_w cycles, data phase d_w more cycles, then HOLD for h_w+1 cycles.
  task automatic do_txn(input mem_t t, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input int a_w, input int d_w,
                        input int h_w, output int stall_cnt);
    logic [1:0]  off;
    logic        mis, st;
    logic [2:0]  esz;
    logic [3:0]  estb;
    logic [31:0] edat;
    logic [3:0]  got4, exp4;
    logic [38:0] gotr, expr;
    logic [40:0] goth, exph;
    off = addr[1:0];
    case (t)
      MEM_LB, MEM_LBU, MEM_SB: esz = 3'd0;
      MEM_LH, MEM_LHU, MEM_SH: esz = 3'd1;
      default:                 esz = 3'd2;
    endcase
    mis  = (esz == 3'd1 && (addr % 2) != 0) || (esz == 3'd2 && (addr % 4) != 0);
    st   = (t == MEM_SB) || (t == MEM_SH) || (t == MEM_SW);
    estb = 4'd0;
    edat = 32'd0;
    if (t == MEM_SB) begin
      estb = 4'(32'd1 << off);
      edat = (wd & 32'h0000_00FF) * 32'h0101_0101;
    end else if (t == MEM_SH) begin
      estb = (off >= 2'd2) ? 4'd12 : 4'd3;
      edat = (wd & 32'h0000_FFFF) * 32'h0001_0001;
    end else if (t == MEM_SW) begin
      estb = 4'd15;
      edat = wd;
    end
    stall_cnt = 0;

    @(negedge clk);
    req_valid = 1'b1; req_type = t; req_addr = addr; req_wdata = wd;
    flush = 1'b0; mem_ready = 1'b0; dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
    dresp_data = $urandom;
    #1;
    if (stall) stall_cnt++;
    got4 = {stall, misalign, dreq_valid, done};
    exp4 = {~mis, mis, 1'b0, 1'b0};
    checks++;
    if (got4 !== exp4) begin
      failures++;
      $display("FAIL accept t=%0d addr=%h {stall,mis,dv,done} got=%b exp=%b", t, addr, got4, exp4);
    end
    if (mis) begin
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      checks++;
      if ({dreq_valid, done, stall} !== 3'b000) begin
        failures++;
        $display("FAIL misalign_after {dv,done,stall} got=%b exp=000", {dreq_valid, done, stall});
      end
      return;
    end

    for (int k = 1; k <= 1 + a_w + d_w; k++) begin
      @(negedge clk);
      dresp_addr_ok = (k == 1 + a_w);
      dresp_data_ok = (k == 1 + a_w + d_w);
      dresp_data    = dresp_data_ok ? rd : $urandom;
      #1;
      if (stall) stall_cnt++;
      got4 = {stall, dreq_valid, done, misalign};
      exp4 = {1'b1, (k <= 1 + a_w), 1'b0, 1'b0};
      checks++;
      if (got4 !== exp4) begin
        failures++;
        $display("FAIL busy k=%0d {stall,dv,done,mis} got=%b exp=%b", k, got4, exp4);
      end
      if (k <= 1 + a_w) begin
        gotr = {dreq_addr, dreq_size, dreq_strobe};
        expr = {addr, esz, estb};
        checks++;
        if (gotr !== expr) begin
          failures++;
          $display("FAIL req_fields k=%0d got=%h exp=%h", k, gotr, expr);
        end
        if (st) begin
          checks++;
          if (dreq_data !== edat) begin
            failures++;
            $display("FAIL req_data k=%0d got=%h exp=%h", k, dreq_data, edat);
          end
        end
      end
    end

    for (int h = 0; h <= h_w; h++) begin
      @(negedge clk);
      dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = $urandom;
      mem_ready = (h == h_w);
      #1;
      goth = {done, stall, dreq_valid, rdata_raw, rd_offset, rd_type};
      exph = {1'b1, 1'b0, 1'b0, rd, off, t};
      checks++;
      if (goth !== exph) begin
        failures++;
        $display("FAIL hold h=%0d got=%h exp=%h", h, goth, exph);
      end
    end
    last_rdata = rd;

    @(negedge clk);
    req_valid = 1'b0; mem_ready = 1'b0;
    #1;
    checks++;
    if ({done, stall, dreq_valid} !== 3'b000) begin
      failures++;
      $display("FAIL bubble {done,stall,dv} got=%b exp=000", {done, stall, dreq_valid});
    end
  endtask

  task automatic test_reset();
    logic [43:0] got;
    @(negedge clk);
    #1;
    got = {dreq_valid, stall, done, misalign, rdata_raw, rd_offset, rd_type};
    checks++;
    if (got !== {4'b0000, 32'h0, 2'b00, MEM_NONE}) begin
      failures++;
      $display("FAIL reset_values got=%h exp=0", got);
    end
  endtask

  task automatic test_sw_fast();
    int sc;
    do_txn(MEM_SW, 32'h8000_0010, 32'hDEAD_BEEF, 32'h1357_9BDF, 0, 0, 0, sc);
  endtask

  task automatic test_sb();
    int sc;
    do_txn(MEM_SB, 32'h8000_0013, 32'h0000_00A5, 32'h2468_ACE0, 1, 0, 0, sc);
  endtask

  task automatic test_lh_slow();
    int sc;
    do_txn(MEM_LH, 32'h8000_0002, 32'h0, 32'h8001_1234, 1, 3, 0, sc);
    checks++;
    if (sc !== 6) begin
      failures++;
      $display("FAIL lh_stall_cycles got=%0d exp=6", sc);
    end
  endtask

  task automatic test_misalign();
    int sc;
    do_txn(MEM_LW, 32'h8000_0006, 32'h0, 32'h0, 0, 0, 0, sc);
    do_txn(MEM_SH, 32'h8000_0101, 32'h0, 32'h0, 0, 0, 0, sc);
  endtask

  task automatic test_hold_stable();
    int sc;
    do_txn(MEM_LBU, 32'h4000_0021, 32'h0, 32'hCAFE_F00D, 0, 1, 3, sc);
  endtask

  task automatic test_flush_data();
    int sc;
    @(negedge clk);
    req_valid = 1'b1; req_type = MEM_LW; req_addr = 32'h1000_0040; req_wdata = 32'h0;
    flush = 1'b0; mem_ready = 1'b0; dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
    @(negedge clk);
    dresp_addr_ok = 1'b1;
    @(negedge clk);
    dresp_addr_ok = 1'b0; flush = 1'b1;
    #1;
    checks++;
    if ({stall, done, dreq_valid} !== 3'b100) begin
      failures++;
      $display("FAIL flush_data {stall,done,dv} got=%b exp=100", {stall, done, dreq_valid});
    end
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++;
    if ({stall, done, dreq_valid} !== 3'b100) begin
      failures++;
      $display("FAIL flush_drain {stall,done,dv} got=%b exp=100", {stall, done, dreq_valid});
    end
    @(negedge clk);
    req_valid = 1'b0; dresp_data_ok = 1'b1; dresp_data = 32'hBAD0_BAD0;
    #1;
    checks++;
    if ({stall, done} !== 2'b00) begin
      failures++;
      $display("FAIL flush_dataok {stall,done} got=%b exp=00", {stall, done});
    end
    @(negedge clk);
    dresp_data_ok = 1'b0;
    #1;
    checks++;
    if ({done, rdata_raw} !== {1'b0, last_rdata}) begin
      failures++;
      $display("FAIL flush_discard {done,rdata} got=%h exp=%h", {done, rdata_raw}, {1'b0, last_rdata});
    end
    do_txn(MEM_LHU, 32'h1000_0046, 32'h0, 32'h7777_0001, 0, 0, 0, sc);
  endtask

  task automatic test_random();
    mem_t types[8];
    int sc;
    types = '{MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_SB, MEM_SH, MEM_SW};
    for (int i = 0; i < 40; i++) begin
      do_txn(types[$urandom_range(0, 7)], $urandom, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), sc);
    end
  endtask

  task automatic test_reset_mid();
    logic [43:0] got;
    @(negedge clk);
    req_valid = 1'b1; req_type = MEM_LH; req_addr = 32'h0000_0102; req_wdata = 32'h0;
    flush = 1'b0; mem_ready = 1'b0; dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
    @(negedge clk);
    dresp_addr_ok = 1'b1;
    @(negedge clk);
    dresp_addr_ok = 1'b0; reset = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    #1;
    got = {dreq_valid, stall, done, misalign, rdata_raw, rd_offset, rd_type};
    checks++;
    if (got !== {4'b0000, 32'h0, 2'b00, MEM_NONE}) begin
      failures++;
      $display("FAIL reset_mid got=%h exp=0", got);
    end
    reset = 1'b0;
    last_rdata = 32'h0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_type = MEM_NONE; req_addr = 32'h0;
    req_wdata = 32'h0; mem_ready = 1'b0; flush = 1'b0;
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = 32'h0;
    repeat (2) @(posedge clk);
    test_reset();
    reset = 1'b0;
    test_sw_fast();
    test_sb();
    test_lh_slow();
    test_misalign();
    test_hold_stable();
    test_flush_data();
    test_random();
    test_reset_mid();
    test_sw_fast();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
